// File: rtl/daq2_spi_pkg.sv
// -----------------------------------------------------------------------------
// daq2_spi_pkg
// Shared types and constants for the DAQ2 3-wire SPI responder model.
//   spi_state_t   : responder transaction state
//   INSTR_BITS    : instruction length (R/nW + 15-bit address)
//   DATA_BITS     : data byte length
//   RW_BIT        : instruction bit carrying R/nW (1 = read)
//   CHIP_ID_ADDR  : read-only identification register address
// -----------------------------------------------------------------------------
package daq2_spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INSTR,
        ST_WDATA,
        ST_RDATA
    } spi_state_t;

    localparam int unsigned INSTR_BITS   = 16;
    localparam int unsigned DATA_BITS    = 8;
    localparam int unsigned RW_BIT       = 15;
    localparam logic [14:0] CHIP_ID_ADDR = 15'h001;

    // Bus addresses are 15 bits wide and wrap from 0x7FFF to 0x0000.
    function automatic logic [14:0] addr_inc(input logic [14:0] a);
        return a + 15'd1;
    endfunction

endpackage

// File: rtl/spi_in_sync.sv
// -----------------------------------------------------------------------------
// spi_in_sync
// Two-flop synchronizer for an asynchronous SPI pin with registered edge pulses.
//   clk   in  system clock
//   reset in  synchronous, active-high
//   din   in  asynchronous pin
//   dout  out synchronized level (second flop)
//   rise  out one-cycle pulse, high in the same cycle dout first shows 1
//   fall  out one-cycle pulse, high in the same cycle dout first shows 0
// -----------------------------------------------------------------------------
module spi_in_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic vld1;
    logic vld2;

    // Pulses are computed from s1 versus s2 so that they line up with the
    // cycle in which s2 takes the new value. vld1/vld2 hold the pulses off
    // until both flops carry real pin samples, so a pin already at its
    // active level when reset is released does not produce a false edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1   <= RESET_VAL;
            s2   <= RESET_VAL;
            vld1 <= 1'b0;
            vld2 <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s1   <= din;
            s2   <= s1;
            vld1 <= 1'b1;
            vld2 <= vld1;
            rise <= vld2 & s1 & ~s2;
            fall <= vld2 & ~s1 & s2;
        end
    end

    assign dout = s2;

endmodule

// File: rtl/daq2_spi_slave_model.sv
// -----------------------------------------------------------------------------
// daq2_spi_slave_model
// Oversampled 3-wire SPI register-file responder (16-bit instruction, 8-bit
// data, address auto-increment). Read-only CHIP_ID lives at address 0x001.
//   clk        in  system clock, all logic on rising edge
//   reset      in  synchronous, active-high; also clears the register file
//   spi_csn    in  chip select, active low, asynchronous
//   spi_clk    in  SPI clock, idle low, asynchronous
//   sdio_i     in  shared data line, input side
//   sdio_o     out read data bit, MSB first, updated on spi_clk falls
//   sdio_oe    out drive enable for sdio_o during the read phase
//   reg_wr     out one-cycle strobe per completed write byte
//   reg_addr   out address of the strobed byte
//   reg_wdata  out data of the strobed byte
//   busy       out synchronized chip-select active
// -----------------------------------------------------------------------------
module daq2_spi_slave_model
    import daq2_spi_pkg::*;
#(
    parameter int unsigned ADDR_W  = 5,
    parameter logic [7:0]  CHIP_ID = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_csn,
    input  logic        spi_clk,
    input  logic        sdio_i,
    output logic        sdio_o,
    output logic        sdio_oe,
    output logic        reg_wr,
    output logic [14:0] reg_addr,
    output logic [7:0]  reg_wdata,
    output logic        busy
);

    localparam int unsigned ENTRIES = 2 ** ADDR_W;

    // ------------------------------------------------------------------
    // Pin synchronization
    // ------------------------------------------------------------------
    logic csn_s;
    logic csn_rise;
    logic csn_fall;
    logic sclk_s;
    logic sclk_rise_p;
    logic sclk_fall_p;
    logic sclk_rise;
    logic sclk_fall;
    logic sdio_m;
    logic sdio_s;

    spi_in_sync #(.RESET_VAL(1'b1)) u_csn_sync (
        .clk   (clk),
        .reset (reset),
        .din   (spi_csn),
        .dout  (csn_s),
        .rise  (csn_rise),
        .fall  (csn_fall)
    );

    spi_in_sync #(.RESET_VAL(1'b0)) u_sclk_sync (
        .clk   (clk),
        .reset (reset),
        .din   (spi_clk),
        .dout  (sclk_s),
        .rise  (sclk_rise_p),
        .fall  (sclk_fall_p)
    );

    // Edge pulses are only acted on when the synchronized level agrees
    // with them, keeping rise and fall handling mutually exclusive.
    assign sclk_rise = sclk_rise_p & sclk_s;
    assign sclk_fall = sclk_fall_p & ~sclk_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            sdio_m <= 1'b0;
            sdio_s <= 1'b0;
        end else begin
            sdio_m <= sdio_i;
            sdio_s <= sdio_m;
        end
    end

    assign busy = ~csn_s;

    // ------------------------------------------------------------------
    // Register file (flop array so reset can clear it)
    // ------------------------------------------------------------------
    logic [7:0]        rf [ENTRIES];
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [7:0]        rf_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                rf[i] <= '0;
            end
        end else if (rf_we) begin
            rf[rf_waddr] <= rf_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Transaction state
    // ------------------------------------------------------------------
    spi_state_t  state;
    spi_state_t  state_n;
    logic [4:0]  cnt;
    logic [4:0]  cnt_n;
    logic [15:0] shreg;
    logic [15:0] shreg_n;
    logic [14:0] addr;
    logic [14:0] addr_n;
    logic [7:0]  tx;
    logic [7:0]  tx_n;
    logic        sdio_o_n;
    logic        oe_n;
    logic        reg_wr_n;
    logic [14:0] reg_addr_n;
    logic [7:0]  reg_wdata_n;

    logic [15:0] shift_in;
    logic        addr_in_range;
    logic [7:0]  rd_byte;

    assign shift_in      = {shreg[14:0], sdio_s};
    assign addr_in_range = ((addr >> ADDR_W) == '0);
    assign rf_waddr      = addr[ADDR_W-1:0];
    assign rf_wdata      = shift_in[7:0];

    always_comb begin
        rd_byte = '0;
        if (addr == CHIP_ID_ADDR) begin
            rd_byte = CHIP_ID;
        end else if (addr_in_range) begin
            rd_byte = rf[addr[ADDR_W-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            shreg     <= '0;
            addr      <= '0;
            tx        <= '0;
            sdio_o    <= 1'b0;
            sdio_oe   <= 1'b0;
            reg_wr    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            shreg     <= shreg_n;
            addr      <= addr_n;
            tx        <= tx_n;
            sdio_o    <= sdio_o_n;
            sdio_oe   <= oe_n;
            reg_wr    <= reg_wr_n;
            reg_addr  <= reg_addr_n;
            reg_wdata <= reg_wdata_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        shreg_n     = shreg;
        addr_n      = addr;
        tx_n        = tx;
        sdio_o_n    = sdio_o;
        oe_n        = sdio_oe;
        reg_wr_n    = 1'b0;
        reg_addr_n  = reg_addr;
        reg_wdata_n = reg_wdata;
        rf_we       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (csn_fall) begin
                    state_n = ST_INSTR;
                    cnt_n   = '0;
                    shreg_n = '0;
                end
            end

            ST_INSTR: begin
                if (sclk_rise) begin
                    shreg_n = shift_in;
                    if (cnt == 5'(INSTR_BITS - 1)) begin
                        cnt_n   = '0;
                        addr_n  = shift_in[14:0];
                        state_n = shift_in[RW_BIT] ? ST_RDATA : ST_WDATA;
                    end else begin
                        cnt_n = cnt + 5'd1;
                    end
                end
            end

            ST_WDATA: begin
                if (sclk_rise) begin
                    shreg_n = shift_in;
                    if (cnt == 5'(DATA_BITS - 1)) begin
                        cnt_n       = '0;
                        reg_wr_n    = 1'b1;
                        reg_addr_n  = addr;
                        reg_wdata_n = shift_in[7:0];
                        rf_we       = addr_in_range && (addr != CHIP_ID_ADDR);
                        addr_n      = addr_inc(addr);
                    end else begin
                        cnt_n = cnt + 5'd1;
                    end
                end
            end

            ST_RDATA: begin
                // cnt == 0 marks a byte boundary: fetch the byte at the
                // current address and present its MSB; the address moves
                // on together with the last bit of each byte.
                if (sclk_fall) begin
                    oe_n = 1'b1;
                    if (cnt == '0) begin
                        sdio_o_n = rd_byte[7];
                        tx_n     = {rd_byte[6:0], 1'b0};
                        cnt_n    = 5'd1;
                    end else begin
                        sdio_o_n = tx[7];
                        tx_n     = {tx[6:0], 1'b0};
                        if (cnt == 5'(DATA_BITS - 1)) begin
                            cnt_n  = '0;
                            addr_n = addr_inc(addr);
                        end else begin
                            cnt_n = cnt + 5'd1;
                        end
                    end
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // Chip-select release wins over everything except a byte that
        // completes in this same cycle (its strobe is already set above).
        if (csn_rise) begin
            state_n  = ST_IDLE;
            cnt_n    = '0;
            oe_n     = 1'b0;
            sdio_o_n = 1'b0;
        end
    end

endmodule

// File: tb/tb_daq2_spi_slave_model.sv
module tb_daq2_spi_slave_model;

    logic        clk = 1'b0;
    logic        reset;
    logic        spi_csn;
    logic        spi_clk;
    logic        sdio_i;
    logic        sdio_o;
    logic        sdio_oe;
    logic        reg_wr;
    logic [14:0] reg_addr;
    logic [7:0]  reg_wdata;
    logic        busy;

    daq2_spi_slave_model #(.ADDR_W(5), .CHIP_ID(8'hA5)) dut (
        .clk       (clk),
        .reset     (reset),
        .spi_csn   (spi_csn),
        .spi_clk   (spi_clk),
        .sdio_i    (sdio_i),
        .sdio_o    (sdio_o),
        .sdio_oe   (sdio_oe),
        .reg_wr    (reg_wr),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    int unsigned cyc = 0;
    int unsigned last_rise_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [14:0] a;
        logic [7:0]  d;
        int unsigned lat;
    } wr_t;
    wr_t wr_q[$];

    // Every cycle reg_wr is seen high becomes one entry, so a stretched
    // strobe shows up as an extra entry.
    always @(negedge clk) begin
        if (!reset && reg_wr) wr_q.push_back('{reg_addr, reg_wdata, cyc - last_rise_cyc});
    end

    // Reference model: 32-entry byte memory, CHIP_ID at 0x001.
    logic [7:0] mem [32];
    logic [7:0] txd_q[$];
    logic [7:0] rxd_q[$];
    logic       rx_oe_all;

    function automatic logic [7:0] model_rd(input logic [14:0] a);
        if (a == 15'h001) return 8'hA5;
        if (a < 15'd32)   return mem[a[4:0]];
        return 8'h00;
    endfunction

    function automatic void model_wr(input logic [14:0] a, input logic [7:0] d);
        if (a < 15'd32 && a != 15'h001) mem[a[4:0]] = d;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_bit(input logic din, output logic dout, output logic oe);
        int unsigned ph;
        ph = $urandom_range(4, 6);
        sdio_i = din;
        tick(int'(ph));
        dout = sdio_o;
        oe   = sdio_oe;
        spi_clk = 1'b1;
        last_rise_cyc = cyc;
        tick(int'(ph));
        spi_clk = 1'b0;
    endtask

    task automatic spi_txn(input logic rd, input logic [14:0] a, input int nbytes, input bit keep_csn);
        logic [15:0] instr;
        logic [7:0]  b;
        logic [7:0]  rb;
        logic        d;
        logic        oeb;
        instr = {rd, a};
        rxd_q.delete();
        rx_oe_all = 1'b1;
        rb = '0;
        spi_csn = 1'b0;
        tick(4);
        for (int i = 15; i >= 0; i--) spi_bit(instr[i], d, oeb);
        for (int n = 0; n < nbytes; n++) begin
            b = '0;
            if (!rd) b = txd_q.pop_front();
            for (int i = 7; i >= 0; i--) begin
                spi_bit(b[i], d, oeb);
                rb[i] = d;
                if (oeb !== 1'b1) rx_oe_all = 1'b0;
            end
            if (rd) rxd_q.push_back(rb);
        end
        tick(2);
        if (!keep_csn) begin
            spi_csn = 1'b1;
            tick(8);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; spi_csn = 1'b1; spi_clk = 1'b0; sdio_i = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        tick(3);
        vectors++; if (sdio_o !== 1'b0)     begin miscompares++; $display("FAIL rst_sdio_o: got %b expected 0", sdio_o); end
        vectors++; if (sdio_oe !== 1'b0)    begin miscompares++; $display("FAIL rst_sdio_oe: got %b expected 0", sdio_oe); end
        vectors++; if (reg_wr !== 1'b0)     begin miscompares++; $display("FAIL rst_reg_wr: got %b expected 0", reg_wr); end
        vectors++; if (reg_addr !== 15'h0)  begin miscompares++; $display("FAIL rst_reg_addr: got %h expected 0000", reg_addr); end
        vectors++; if (reg_wdata !== 8'h0)  begin miscompares++; $display("FAIL rst_reg_wdata: got %h expected 00", reg_wdata); end
        vectors++; if (busy !== 1'b0)       begin miscompares++; $display("FAIL rst_busy: got %b expected 0", busy); end
        reset = 1'b0;
        tick(4);
        vectors++; if (busy !== 1'b0 || sdio_oe !== 1'b0) begin miscompares++; $display("FAIL post_rst_idle: got busy=%b oe=%b expected 0 0", busy, sdio_oe); end
    endtask

    task automatic test_write_read;
        wr_q.delete();
        txd_q.push_back(8'h3C);
        spi_txn(1'b0, 15'h010, 1, 1'b0);
        model_wr(15'h010, 8'h3C);
        vectors++;
        if (wr_q.size() !== 1) begin
            miscompares++; $display("FAIL wr_count: got %0d expected 1", wr_q.size());
        end else begin
            vectors++; if (wr_q[0].a !== 15'h010) begin miscompares++; $display("FAIL wr_addr: got %h expected 0010", wr_q[0].a); end
            vectors++; if (wr_q[0].d !== 8'h3C)   begin miscompares++; $display("FAIL wr_data: got %h expected 3c", wr_q[0].d); end
            vectors++; if (wr_q[0].lat !== 3)     begin miscompares++; $display("FAIL wr_latency: got %0d expected 3", wr_q[0].lat); end
        end
        wr_q.delete();
        spi_txn(1'b1, 15'h010, 1, 1'b1);
        vectors++; if (rxd_q[0] !== model_rd(15'h010)) begin miscompares++; $display("FAIL rd_010: got %h expected %h", rxd_q[0], model_rd(15'h010)); end
        vectors++; if (rx_oe_all !== 1'b1) begin miscompares++; $display("FAIL rd_oe_during_byte: got %b expected 1", rx_oe_all); end
        vectors++; if (wr_q.size() !== 0)  begin miscompares++; $display("FAIL rd_no_wr: got %0d expected 0", wr_q.size()); end
        spi_csn = 1'b1;
        tick(1);
        vectors++; if (busy !== 1'b1 || sdio_oe !== 1'b1) begin miscompares++; $display("FAIL csn_rise_c1: got busy=%b oe=%b expected 1 1", busy, sdio_oe); end
        tick(1);
        vectors++; if (busy !== 1'b0 || sdio_oe !== 1'b1) begin miscompares++; $display("FAIL csn_rise_c2: got busy=%b oe=%b expected 0 1", busy, sdio_oe); end
        tick(1);
        vectors++; if (sdio_oe !== 1'b0) begin miscompares++; $display("FAIL csn_rise_c3_oe: got %b expected 0", sdio_oe); end
        tick(6);
    endtask

    task automatic test_chip_id;
        wr_q.delete();
        txd_q.push_back(8'h00);
        spi_txn(1'b0, 15'h001, 1, 1'b0);
        model_wr(15'h001, 8'h00);
        vectors++; if (wr_q.size() !== 1 || wr_q[0].a !== 15'h001) begin miscompares++; $display("FAIL id_wr_strobe: got n=%0d expected 1 strobe at 0001", wr_q.size()); end
        spi_txn(1'b1, 15'h001, 1, 1'b0);
        vectors++; if (rxd_q[0] !== 8'hA5) begin miscompares++; $display("FAIL id_read: got %h expected a5", rxd_q[0]); end
        spi_txn(1'b1, 15'h010, 1, 1'b0);
        vectors++; if (rxd_q[0] !== model_rd(15'h010)) begin miscompares++; $display("FAIL id_rf_intact: got %h expected %h", rxd_q[0], model_rd(15'h010)); end
    endtask

    task automatic test_stream_write;
        logic [7:0] dat [3];
        dat[0] = 8'h11; dat[1] = 8'h22; dat[2] = 8'h33;
        wr_q.delete();
        for (int i = 0; i < 3; i++) txd_q.push_back(dat[i]);
        spi_txn(1'b0, 15'h01E, 3, 1'b0);
        for (int i = 0; i < 3; i++) model_wr(15'h01E + 15'(i), dat[i]);
        vectors++;
        if (wr_q.size() !== 3) begin
            miscompares++; $display("FAIL stream_wr_count: got %0d expected 3", wr_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (wr_q[i].a !== 15'h01E + 15'(i) || wr_q[i].d !== dat[i] || wr_q[i].lat !== 3) begin
                    miscompares++;
                    $display("FAIL stream_wr[%0d]: got a=%h d=%h lat=%0d expected a=%h d=%h lat=3",
                             i, wr_q[i].a, wr_q[i].d, wr_q[i].lat, 15'h01E + 15'(i), dat[i]);
                end
            end
        end
        spi_txn(1'b1, 15'h01E, 3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (rxd_q[i] !== model_rd(15'h01E + 15'(i))) begin
                miscompares++; $display("FAIL stream_rd[%0d]: got %h expected %h", i, rxd_q[i], model_rd(15'h01E + 15'(i)));
            end
        end
    endtask

    task automatic test_abort;
        logic [15:0] instr;
        logic        d;
        logic        oeb;
        logic [7:0]  v;
        instr = {1'b0, 15'h005};
        wr_q.delete();
        spi_csn = 1'b0;
        tick(4);
        for (int i = 15; i >= 0; i--) spi_bit(instr[i], d, oeb);
        for (int i = 0; i < 5; i++) spi_bit(1'b1, d, oeb);
        tick(2);
        spi_csn = 1'b1;
        tick(8);
        vectors++; if (wr_q.size() !== 0) begin miscompares++; $display("FAIL abort_no_wr: got %0d expected 0", wr_q.size()); end
        vectors++; if (sdio_oe !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL abort_idle: got oe=%b busy=%b expected 0 0", sdio_oe, busy); end
        v = 8'($urandom);
        txd_q.push_back(v);
        spi_txn(1'b0, 15'h005, 1, 1'b0);
        model_wr(15'h005, v);
        vectors++; if (wr_q.size() !== 1 || wr_q[0].a !== 15'h005 || wr_q[0].d !== v) begin miscompares++; $display("FAIL abort_next_wr: got n=%0d expected 1 strobe at 0005 data %h", wr_q.size(), v); end
        spi_txn(1'b1, 15'h005, 1, 1'b0);
        vectors++; if (rxd_q[0] !== model_rd(15'h005)) begin miscompares++; $display("FAIL abort_readback: got %h expected %h", rxd_q[0], model_rd(15'h005)); end
    endtask

    task automatic test_reset_mid_read;
        logic [15:0] instr;
        logic        d;
        logic        oeb;
        instr = {1'b1, 15'h010};
        spi_csn = 1'b0;
        tick(4);
        for (int i = 15; i >= 0; i--) spi_bit(instr[i], d, oeb);
        for (int i = 0; i < 3; i++) spi_bit(1'b0, d, oeb);
        tick(1);
        vectors++; if (sdio_oe !== 1'b1) begin miscompares++; $display("FAIL pre_reset_oe: got %b expected 1", sdio_oe); end
        reset = 1'b1;
        tick(1);
        vectors++; if (sdio_oe !== 1'b0) begin miscompares++; $display("FAIL reset_mid_read_oe: got %b expected 0", sdio_oe); end
        tick(1);
        reset = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        wr_q.delete();
        tick(3);
        // Bus activity while csn is still low from before the reset must be ignored.
        for (int i = 0; i < 24; i++) spi_bit(1'b1, d, oeb);
        tick(2);
        vectors++; if (wr_q.size() !== 0 || sdio_oe !== 1'b0) begin miscompares++; $display("FAIL post_reset_ignored: got wr=%0d oe=%b expected 0 0", wr_q.size(), sdio_oe); end
        spi_csn = 1'b1;
        tick(8);
        spi_txn(1'b1, 15'h010, 1, 1'b0);
        vectors++; if (rxd_q[0] !== model_rd(15'h010)) begin miscompares++; $display("FAIL reset_cleared_010: got %h expected %h", rxd_q[0], model_rd(15'h010)); end
    endtask

    task automatic test_wrap;
        logic [7:0] x;
        logic [7:0] y;
        x = 8'($urandom);
        y = 8'($urandom_range(1, 255));
        wr_q.delete();
        txd_q.push_back(x);
        txd_q.push_back(y);
        spi_txn(1'b0, 15'h7FFF, 2, 1'b0);
        model_wr(15'h7FFF, x);
        model_wr(15'h0000, y);
        vectors++; if (wr_q.size() !== 2 || wr_q[0].a !== 15'h7FFF || wr_q[1].a !== 15'h0000) begin miscompares++; $display("FAIL wrap_wr_addrs: got n=%0d expected strobes at 7fff,0000", wr_q.size()); end
        spi_txn(1'b1, 15'h7FFF, 2, 1'b0);
        vectors++; if (rxd_q[0] !== model_rd(15'h7FFF)) begin miscompares++; $display("FAIL wrap_rd0: got %h expected %h", rxd_q[0], model_rd(15'h7FFF)); end
        vectors++; if (rxd_q[1] !== model_rd(15'h0000)) begin miscompares++; $display("FAIL wrap_rd1: got %h expected %h", rxd_q[1], model_rd(15'h0000)); end
    endtask

    task automatic test_random;
        logic        rd;
        logic [14:0] a;
        int          n;
        logic [7:0]  dat [3];
        for (int t = 0; t < 10; t++) begin
            rd = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) a = 15'h7FFC + 15'($urandom_range(0, 3));
            else                           a = 15'($urandom_range(0, 40));
            n = int'($urandom_range(1, 3));
            if (!rd) begin
                wr_q.delete();
                for (int i = 0; i < n; i++) begin
                    dat[i] = 8'($urandom);
                    txd_q.push_back(dat[i]);
                end
                spi_txn(1'b0, a, n, 1'b0);
                vectors++;
                if (wr_q.size() !== n) begin
                    miscompares++; $display("FAIL rnd_wr_count[%0d]: got %0d expected %0d", t, wr_q.size(), n);
                end else begin
                    for (int i = 0; i < n; i++) begin
                        vectors++;
                        if (wr_q[i].a !== a + 15'(i) || wr_q[i].d !== dat[i] || wr_q[i].lat !== 3) begin
                            miscompares++;
                            $display("FAIL rnd_wr[%0d.%0d]: got a=%h d=%h lat=%0d expected a=%h d=%h lat=3",
                                     t, i, wr_q[i].a, wr_q[i].d, wr_q[i].lat, a + 15'(i), dat[i]);
                        end
                    end
                end
                for (int i = 0; i < n; i++) model_wr(a + 15'(i), dat[i]);
            end else begin
                spi_txn(1'b1, a, n, 1'b0);
                for (int i = 0; i < n; i++) begin
                    vectors++;
                    if (rxd_q[i] !== model_rd(a + 15'(i))) begin
                        miscompares++; $display("FAIL rnd_rd[%0d.%0d]: got %h expected %h at %h", t, i, rxd_q[i], model_rd(a + 15'(i)), a + 15'(i));
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_chip_id;
        test_stream_write;
        test_abort;
        test_reset_mid_read;
        test_wrap;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
